// File: rtl/hamming_pkg.sv
// Shared widths, default sizing and FSM encoding for the hamming weight
// accumulator and its per-byte weight calculator.
package hamming_pkg;

    localparam int BYTE_WIDTH     = 8;
    localparam int WEIGHT_WIDTH   = 4;

    localparam int BYTES_MAX_DEF  = 256;
    localparam int CNT_WIDTH_DEF  = 9;
    localparam int SUM_WIDTH_DEF  = 12;

    typedef enum logic {
        ACCUM  = 1'b0,
        RESULT = 1'b1
    } state_t;

endpackage

// File: rtl/hamming_weight_cal.sv
// Combinational population count of a bit string.
module hamming_weight_cal #(
    parameter int BIT_STRING_LEN = 8
) (
    input  logic [BIT_STRING_LEN-1:0]             bit_string,
    output logic [$clog2(BIT_STRING_LEN+1)-1:0]   weight
);

    localparam int W = $clog2(BIT_STRING_LEN + 1);

    always_comb begin
        weight = '0;
        for (int i = 0; i < BIT_STRING_LEN; i++) begin
            weight = weight + {{(W-1){1'b0}}, bit_string[i]};
        end
    end

endmodule

// File: rtl/hamming_weight_accum.sv
// Streams frame bytes through a two-stage pipeline, accumulating total
// set bits and byte count per frame, and hands the result downstream.
module hamming_weight_accum
    import hamming_pkg::*;
#(
    parameter int BYTES_MAX = BYTES_MAX_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int SUM_WIDTH = SUM_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BYTE_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SUM_WIDTH-1:0]  out_weight,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  out_overflow
);

    state_t state, state_nxt;

    logic                    s1_valid;
    logic                    s1_close;
    logic                    s1_ovf;
    logic [BYTE_WIDTH-1:0]   s1_data;
    logic [SUM_WIDTH-1:0]    sum;
    logic [CNT_WIDTH-1:0]    count;
    logic [WEIGHT_WIDTH-1:0] w;

    logic                    in_fire;
    logic                    out_fire;
    logic                    s2_take;
    logic                    limit_hit;
    logic [CNT_WIDTH:0]      fill;
    logic [SUM_WIDTH-1:0]    sum_nxt;
    logic [CNT_WIDTH-1:0]    count_nxt;

    hamming_weight_cal #(
        .BIT_STRING_LEN(BYTE_WIDTH)
    ) u_cal (
        .bit_string(s1_data),
        .weight    (w)
    );

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign s2_take  = (state == ACCUM) && s1_valid;

    // Position of the incoming byte within the frame, counting the one in S1.
    assign fill = {1'b0, count}
                + {{CNT_WIDTH{1'b0}}, s1_valid}
                + (CNT_WIDTH+1)'(1);
    assign limit_hit = (fill == (CNT_WIDTH+1)'(BYTES_MAX));

    assign sum_nxt   = sum + {{(SUM_WIDTH-WEIGHT_WIDTH){1'b0}}, w};
    assign count_nxt = count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        unique case (state)
            ACCUM: begin
                in_ready = rst_n && !(s1_valid && s1_close);
                if (s1_valid && s1_close) begin
                    state_nxt = RESULT;
                end
            end
            RESULT: begin
                if (out_fire) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_close     <= 1'b0;
            s1_ovf       <= 1'b0;
            s1_data      <= '0;
            sum          <= '0;
            count        <= '0;
            out_valid    <= 1'b0;
            out_weight   <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_data  <= in_data;
                s1_close <= in_last || limit_hit;
                s1_ovf   <= limit_hit && !in_last;
            end

            if (s2_take) begin
                if (s1_close) begin
                    out_valid    <= 1'b1;
                    out_weight   <= sum_nxt;
                    out_count    <= count_nxt;
                    out_overflow <= s1_ovf;
                end else begin
                    sum   <= sum_nxt;
                    count <= count_nxt;
                end
            end

            if (out_fire) begin
                out_valid <= 1'b0;
                sum       <= '0;
                count     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hamming_weight_accum.sv
// Directed bench: default-size instance A and a BYTES_MAX=4 instance B
// for the limit-closed frame cases.
module tb_hamming_weight_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_in_valid, a_in_ready, a_in_last;
    logic [7:0]  a_in_data;
    logic        a_out_valid, a_out_ready, a_out_overflow;
    logic [11:0] a_out_weight;
    logic [8:0]  a_out_count;

    logic        b_in_valid, b_in_ready, b_in_last;
    logic [7:0]  b_in_data;
    logic        b_out_valid, b_out_ready, b_out_overflow;
    logic [5:0]  b_out_weight;
    logic [2:0]  b_out_count;

    hamming_weight_accum dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (a_in_valid),
        .in_ready    (a_in_ready),
        .in_data     (a_in_data),
        .in_last     (a_in_last),
        .out_valid   (a_out_valid),
        .out_ready   (a_out_ready),
        .out_weight  (a_out_weight),
        .out_count   (a_out_count),
        .out_overflow(a_out_overflow)
    );

    hamming_weight_accum #(
        .BYTES_MAX(4),
        .CNT_WIDTH(3),
        .SUM_WIDTH(6)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (b_in_valid),
        .in_ready    (b_in_ready),
        .in_data     (b_in_data),
        .in_last     (b_in_last),
        .out_valid   (b_out_valid),
        .out_ready   (b_out_ready),
        .out_weight  (b_out_weight),
        .out_count   (b_out_count),
        .out_overflow(b_out_overflow)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int w;
        int c;
        bit o;
    } res_t;

    res_t qa[$];
    res_t qb[$];

    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready)
            qa.push_back('{int'(a_out_weight), int'(a_out_count), a_out_overflow});
        if (rst_n && b_out_valid && b_out_ready)
            qb.push_back('{int'(b_out_weight), int'(b_out_count), b_out_overflow});
    end

    typedef struct {
        bit               sel;
        int               n;
        logic [3:0][7:0]  d;
        bit               last;
        int               exp_w;
        int               exp_c;
        bit               exp_o;
    } vec_t;

    vec_t vecs[9];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(bit sel, bit v, logic [7:0] d, bit last);
        if (sel) begin
            b_in_valid = v; b_in_data = d; b_in_last = last;
        end else begin
            a_in_valid = v; a_in_data = d; a_in_last = last;
        end
    endtask

    task automatic send_byte(bit sel, logic [7:0] d, bit last);
        int  n = 0;
        bit  done = 0;
        drive(sel, 1'b1, d, last);
        while (!done) begin
            @(negedge clk);
            if ((sel ? b_in_ready : a_in_ready) === 1'b1) done = 1;
            @(posedge clk); #1;
            if (!done) begin
                n++;
                if (n > 60) begin
                    checks++; errors++;
                    $display("FAIL send_timeout: got no in_ready expected in_ready=1");
                    done = 1;
                end
            end
        end
    endtask

    task automatic idle(bit sel);
        drive(sel, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic get_result(bit sel, output res_t r);
        int n = 0;
        r = '{-1, -1, 1'b0};
        while ((sel ? qb.size() : qa.size()) == 0 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if ((sel ? qb.size() : qa.size()) == 0) begin
            checks++; errors++;
            $display("FAIL result_timeout: got no result expected one");
        end else if (sel) begin
            r = qb.pop_front();
        end else begin
            r = qa.pop_front();
        end
    endtask

    res_t r;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 3, 32'h00_01_0F_FF, 1, 13, 3, 0};
        vecs[1] = '{0, 1, 32'h00_00_00_00, 1,  0, 1, 0};
        vecs[2] = '{0, 1, 32'h00_00_00_A5, 1,  4, 1, 0};
        vecs[3] = '{0, 4, 32'h0F_F0_AA_55, 1, 16, 4, 0};
        vecs[4] = '{0, 2, 32'h00_00_00_00, 1,  0, 2, 0};
        vecs[5] = '{1, 4, 32'hFF_FF_FF_FF, 0, 32, 4, 1};
        vecs[6] = '{1, 2, 32'h00_00_FF_FF, 1, 16, 2, 0};
        vecs[7] = '{1, 4, 32'h0F_07_03_01, 1, 10, 4, 0};
        vecs[8] = '{1, 1, 32'h00_00_00_80, 1,  1, 1, 0};

        // Reset held with in_valid high on both instances
        rst_n = 1'b0;
        drive(0, 1'b1, 8'hFF, 1'b0);
        drive(1, 1'b1, 8'hFF, 1'b0);
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_a_in_ready", a_in_ready, 0);
        check("rst_b_in_ready", b_in_ready, 0);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_weight", a_out_weight, 0);
        check("rst_out_count", a_out_count, 0);
        check("rst_out_overflow", a_out_overflow, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(0);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_out_valid", a_out_valid, 0);
        end
        check("post_rst_in_ready", a_in_ready, 1);
        check("post_rst_no_result", qa.size(), 0);
        @(posedge clk); #1;

        // Latency and one-cycle result pulse
        send_byte(0, 8'hFF, 0);
        send_byte(0, 8'h0F, 0);
        send_byte(0, 8'h01, 1);
        idle(0);
        @(negedge clk);
        check("lat_valid_c1", a_out_valid, 0);
        check("lat_in_ready_c1", a_in_ready, 0);
        @(negedge clk);
        check("lat_valid_c2", a_out_valid, 1);
        check("lat_weight", a_out_weight, 13);
        @(negedge clk);
        check("lat_valid_c3", a_out_valid, 0);
        get_result(0, r);
        check("lat_res_w", r.w, 13);
        check("lat_res_c", r.c, 3);
        check("lat_res_o", r.o, 0);
        @(posedge clk); #1;

        foreach (vecs[k]) begin
            for (int i = 0; i < vecs[k].n; i++)
                send_byte(vecs[k].sel, vecs[k].d[i], vecs[k].last && (i == vecs[k].n - 1));
            idle(vecs[k].sel);
            get_result(vecs[k].sel, r);
            check($sformatf("vec%0d_weight", k), r.w, vecs[k].exp_w);
            check($sformatf("vec%0d_count", k), r.c, vecs[k].exp_c);
            check($sformatf("vec%0d_overflow", k), r.o, vecs[k].exp_o);
        end

        // Output stall with a new byte waiting at the input
        a_out_ready = 1'b0;
        send_byte(0, 8'h80, 0);
        send_byte(0, 8'h81, 1);
        drive(0, 1'b1, 8'h7F, 1'b0);
        for (int i = 0; i < 10 && a_out_valid !== 1'b1; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", a_out_valid, 1);
            check("stall_weight", a_out_weight, 3);
            check("stall_count", a_out_count, 2);
            check("stall_in_ready", a_in_ready, 0);
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        get_result(0, r);
        check("stall_res_w", r.w, 3);
        check("stall_res_c", r.c, 2);
        send_byte(0, 8'h7F, 0);
        send_byte(0, 8'h3C, 1);
        idle(0);
        get_result(0, r);
        check("after_stall_w", r.w, 11);
        check("after_stall_c", r.c, 2);
        check("after_stall_o", r.o, 0);

        // Reset with a partial frame in flight
        @(posedge clk); #1;
        send_byte(0, 8'h11, 0);
        send_byte(0, 8'h22, 0);
        idle(0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("midrst_out_valid", a_out_valid, 0);
        end
        check("midrst_no_result", qa.size(), 0);
        @(posedge clk); #1;
        send_byte(0, 8'h03, 1);
        idle(0);
        get_result(0, r);
        check("midrst_res_w", r.w, 2);
        check("midrst_res_c", r.c, 1);
        check("midrst_res_o", r.o, 0);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
